// File: rtl/packet_proto_pkg.sv
// packet_proto_pkg
//   Shared host-link framing definitions, used by both the transmit-side
//   packet_encode_fsm and the far-end decode FSM so the two ends agree on
//   the sync words, the command field and the count-word byte order.
//   Contents:
//     WORD_W            - link word width
//     RESYNC_WORD       - word that forces the far-end decoder back to idle
//     SOP_WORD          - start-of-packet marker
//     cmd_t             - 2-bit command type
//     enc_state_t       - transmit framer state encoding (3 bits)
//     byte_swap()       - count-word byte reversal
//     cmd_word()        - command word builder
package packet_proto_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESYNC_WORD = 32'h1EDC6F41;
  localparam logic [WORD_W-1:0] SOP_WORD    = 32'h741B8CD7;

  typedef enum logic [1:0] {
    CMD_TYPE0 = 2'd0,
    CMD_TYPE1 = 2'd1,
    CMD_TYPE2 = 2'd2,
    CMD_TYPE3 = 2'd3
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESYNC  = 3'd1,
    ST_SOP     = 3'd2,
    ST_CMD     = 3'd3,
    ST_NUMW    = 3'd4,
    ST_PAYLOAD = 3'd5
  } enc_state_t;

  // The count word travels least-significant byte first.
  function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Command lives in bits [25:24]; all other bits are zero.
  function automatic logic [WORD_W-1:0] cmd_word(input cmd_t c);
    logic [1:0] bits;
    bits = c;
    return {6'b0, bits, 24'h0};
  endfunction

endpackage

// File: rtl/word_out_reg.sv
// word_out_reg
//   Single-entry valid/ready holding register for the framed output word.
//   The owner loads a word only when can_load is high (register empty or
//   its current word is leaving this cycle), so a loaded word is never
//   overwritten before it transfers.  Data is held stable while valid is
//   high and ready is low.
//   Ports:
//     clk, reset      - clock, asynchronous active-high reset
//     load, load_data - write a new word (sets valid)
//     ready           - downstream accepts the held word
//     valid, data     - held word
//     xfer            - valid && ready this cycle
//     can_load        - register may be loaded this cycle
module word_out_reg
  import packet_proto_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [WORD_W-1:0] data,
  output logic              xfer,
  output logic              can_load
);

  assign xfer     = valid && ready;
  assign can_load = !valid || ready;

  // Data is cleared on reset as well so the link shows all-zero outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/packet_encode_fsm.sv
// packet_encode_fsm
//   Transmit-side framer for the host link.  On an accepted request it
//   emits START_OF_PACKET, the command word, the byte-swapped word count
//   and then N payload words pulled from the upstream word FIFO.  A RESYNC
//   word can be injected on request; mid-packet it aborts the frame after
//   the word currently held in the output register has transferred.
//   Parameters:
//     RESYNC_BEFORE_SOP - precede every packet with one RESYNC word
//   Ports:
//     i_clk, i_reset                      - clock, async active-high reset
//     i_start, i_command, i_num_words     - packet request (IDLE only)
//     i_resync                            - RESYNC request / abort
//     i_payload_valid, i_payload_data,
//     o_payload_ready                     - upstream payload handshake
//     o_word_valid, o_word_data,
//     i_word_ready                        - downstream word handshake
//     o_busy                              - not in IDLE
//     o_packet_sent                       - pulse after last payload transfer
//     o_err_zero_len                      - pulse on rejected N=0 request
module packet_encode_fsm
  import packet_proto_pkg::*;
#(
  parameter bit RESYNC_BEFORE_SOP = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_command,
  input  logic [WORD_W-1:0] i_num_words,
  input  logic              i_resync,
  input  logic              i_payload_valid,
  input  logic [WORD_W-1:0] i_payload_data,
  output logic              o_payload_ready,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word_data,
  input  logic              i_word_ready,
  output logic              o_busy,
  output logic              o_packet_sent,
  output logic              o_err_zero_len
);

  enc_state_t        state_q, state_d;
  cmd_t              cmd_q;
  logic [WORD_W-1:0] count_q, count_d;
  logic              pre_sop_q, pre_sop_d;
  logic              pending_q, pending_d;
  logic              sent_q, sent_d;
  logic              err_q, err_d;
  logic              capture;
  logic              abort_req;

  logic              out_load;
  logic [WORD_W-1:0] out_load_data;
  logic              out_xfer;
  logic              out_can_load;
  logic              payload_ready;

  word_out_reg u_word_out (
    .clk       (i_clk),
    .reset     (i_reset),
    .load      (out_load),
    .load_data (out_load_data),
    .ready     (i_word_ready),
    .valid     (o_word_valid),
    .data      (o_word_data),
    .xfer      (out_xfer),
    .can_load  (out_can_load)
  );

  // An abort request seen this cycle acts immediately; one seen earlier is
  // remembered in pending_q until the RESYNC word has been loaded.
  assign abort_req = pending_q || i_resync;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    pre_sop_d     = pre_sop_q;
    pending_d     = pending_q || ((state_q != ST_IDLE) && i_resync);
    sent_d        = 1'b0;
    err_d         = 1'b0;
    capture       = 1'b0;
    out_load      = 1'b0;
    out_load_data = '0;
    payload_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pending_d = 1'b0;
        pre_sop_d = 1'b0;
        if (i_resync) begin
          // A simultaneous start is dropped: only the RESYNC word goes out.
          out_load      = 1'b1;
          out_load_data = RESYNC_WORD;
          state_d       = ST_RESYNC;
        end else if (i_start) begin
          if (i_num_words == '0) begin
            err_d = 1'b1;
          end else begin
            capture  = 1'b1;
            count_d  = i_num_words;
            out_load = 1'b1;
            if (RESYNC_BEFORE_SOP) begin
              out_load_data = RESYNC_WORD;
              pre_sop_d     = 1'b1;
              state_d       = ST_RESYNC;
            end else begin
              out_load_data = SOP_WORD;
              state_d       = ST_SOP;
            end
          end
        end
      end

      ST_RESYNC: begin
        if (out_xfer) begin
          pre_sop_d = 1'b0;
          pending_d = 1'b0;
          // An abort during the pre-SOP RESYNC is already satisfied by it.
          if (pre_sop_q && !abort_req) begin
            out_load      = 1'b1;
            out_load_data = SOP_WORD;
            state_d       = ST_SOP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_SOP, ST_CMD, ST_NUMW: begin
        if (out_xfer) begin
          if (abort_req) begin
            out_load      = 1'b1;
            out_load_data = RESYNC_WORD;
            pending_d     = 1'b0;
            state_d       = ST_RESYNC;
          end else if (state_q == ST_SOP) begin
            out_load      = 1'b1;
            out_load_data = cmd_word(cmd_q);
            state_d       = ST_CMD;
          end else if (state_q == ST_CMD) begin
            out_load      = 1'b1;
            out_load_data = byte_swap(count_q);
            state_d       = ST_NUMW;
          end else begin
            // The first payload word may replace the count word in the same
            // cycle it leaves, keeping the stream gap-free.
            payload_ready = 1'b1;
            if (i_payload_valid) begin
              out_load      = 1'b1;
              out_load_data = i_payload_data;
              count_d       = count_q - 32'd1;
            end
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (abort_req) begin
          // Payload intake stops; RESYNC follows once the held word is gone.
          if (out_can_load) begin
            out_load      = 1'b1;
            out_load_data = RESYNC_WORD;
            pending_d     = 1'b0;
            state_d       = ST_RESYNC;
          end
        end else if (count_q == '0) begin
          // All N words consumed; the register holds the last one.
          if (out_xfer) begin
            sent_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          payload_ready = out_can_load;
          if (out_can_load && i_payload_valid) begin
            out_load      = 1'b1;
            out_load_data = i_payload_data;
            count_d       = count_q - 32'd1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
        pre_sop_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      pre_sop_q <= 1'b0;
      pending_q <= 1'b0;
      sent_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_sop_q <= pre_sop_d;
      pending_q <= pending_d;
      sent_q    <= sent_d;
      err_q     <= err_d;
    end
  end

  // Request fields and the payload counter are only meaningful outside
  // IDLE and are always written before use, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      cmd_q <= cmd_t'(i_command);
    end
    count_q <= count_d;
  end

  assign o_payload_ready = payload_ready;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_packet_sent   = sent_q;
  assign o_err_zero_len  = err_q;

endmodule
